maze_path_solver: RTL
=====================

Name: maze_path_solver

Overview:
- Parametrised N×N rat-in-a-maze solver.
- Loads the maze one row per cycle, then runs a depth-first search from the top-right cell (0,N-1) to the bottom-left cell (N-1,0). Legal moves are down (row+1) and toward column 0 (col-1).
- Uses an explicit path stack plus a dead-cell bitmap, so every cell is explored at most once.
- Streams the found path out one cell per cycle, or signals "no path".
- Sits between the maze-input stage and the path-consumer / scoreboard in the maze subsystem.

Parameters:
- N, 8, maze dimension (rows = cols = N); legal range 2..16.
- RW, $clog2(N), width of the row/col coordinates (derived; do not override).
- PD, 2*N-1, path stack depth = cells on any monotone path (derived).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  maze row valid; N consecutive cycles, row 0 first
- maze  in  N  one row; maze[c]=1 means cell (r,c) is open
- busy  out  1  high from the first accepted row until the output ends
- out_valid  out  1  output beat valid
- out_row  out  RW  path cell row (0 when out_valid=0)
- out_col  out  RW  path cell col (0 when out_valid=0)
- out_last  out  1  final beat of the path, or the single no-path beat
- no_path  out  1  qualifies the single beat that reports no solution

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset state: all outputs 0, FSM in IDLE, stack pointer 0, dead bitmap cleared. Reset mid-operation aborts immediately; no partial output follows.
- FSM states: IDLE, LOAD, CHECK, SEARCH, OUTPUT, FAIL.
- IDLE: in_valid=1 stores row 0, sets busy, and moves to LOAD with row count 1.
- LOAD: each in_valid cycle stores the next row. After row N-1 is stored, go to CHECK.
  - If in_valid drops before N rows: discard, return to IDLE, busy=0, no output.
- CHECK (1 cycle): clear the dead bitmap.
  - Start (0,N-1) or goal (N-1,0) blocked → FAIL.
  - Otherwise push (0,N-1), sp=1, go to SEARCH.
- SEARCH: exactly one action per cycle on top-of-stack cell (r,c):
  - 1. If (r,c)==(N-1,0): go to OUTPUT.
  - 2. Else if r<N-1 and (r+1,c) is open and not dead: push (r+1,c).
  - 3. Else if c>0 and (r,c-1) is open and not dead: push (r,c-1).
  - 4. Else mark (r,c) dead and pop. If sp becomes 0 → FAIL.
  - Down takes priority over col-1. Boundary tests use the unsigned coordinates only; no wrap-around.
  - Search bound: ≤ 2·N² cycles. Exceeding it is a design error (assertion).
- OUTPUT: emits stack[0..sp-1] on consecutive cycles, exactly 2N-1 beats with out_valid=1. out_last is set on the beat for (N-1,0).
  - Next cycle: IDLE, busy=0, all outputs 0.
- FAIL: one beat with out_valid=1, no_path=1, out_last=1, row=col=0. Then IDLE.
- in_valid is ignored while in CHECK, SEARCH, OUTPUT or FAIL. A new maze may start on the cycle after busy falls.
- Output latency: first out_valid exactly one cycle after the SEARCH cycle that detects the goal. There is no backpressure.

Decomposition:
- Shared package maze_pkg holds:
  - the state enum
  - the coordinate struct {row, col} sized by RW
  - the start/goal corner constants as functions of N
- One natural sub-module: maze_path_stack (PD-deep coordinate LIFO with push/pop, sp, and indexed read for OUTPUT).
- Maze storage and the dead bitmap stay in the top as N×N flop arrays.

Test Plan:
- All-open 8×8 → 15 beats: (0,7),(1,7)..(7,7),(7,6)..(7,0). out_last on beat 15. no_path never set.
- Rows 0x80,0x80,0x80,0xFF,0x00,.. (rows 4-7 = 0x00) → goal blocked → single beat no_path=1, out_last=1 one cycle after CHECK.
- Dead end: column 7 open for rows 0-5, row 6 col 7 blocked, (5,6) closed; row 0 fully open; column 0 open for rows 0-7 → search pops rows 5..1 of column 7, marks them dead, then takes row 0 westward and column 0 down. Output is 15 beats and contains no dead cell.
- Start cell blocked (row 0 = 0x7F) → no_path beat. Stack is never pushed.
- in_valid drops after 5 rows → no output, busy=0 next cycle. A following full, all-open maze then solves normally.
- N=4 build, all-open → 7 beats (0,3),(1,3),(2,3),(3,3),(3,2),(3,1),(3,0). Assert rst_n low on beat 3 → out_valid=0 immediately and busy=0.

Source files
------------

// File: rtl/maze_path_solver_pkg.sv
// Shared types for the maze solver: FSM states, cell coordinates and corner cells.
package maze_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, SEARCH, OUTPUT, FAIL} state_t;

   // Coordinate fields are sized for the largest legal maze (N=16).
   localparam int CW = 4;

   typedef struct packed {
      logic [CW-1:0] row;
      logic [CW-1:0] col;
   } coord_t;

   function automatic coord_t start_cell(input int n);
      coord_t c;
      c.row = '0;
      c.col = CW'(n - 1);
      return c;
   endfunction

   function automatic coord_t goal_cell(input int n);
      coord_t c;
      c.row = CW'(n - 1);
      c.col = '0;
      return c;
   endfunction

endpackage

// File: rtl/maze_path_solver_if.sv
// Maze row input and path beat output of the solver.
interface maze_path_solver_if #(parameter int N = 8);

   localparam int RW = $clog2(N);

   logic          in_valid;
   logic [N-1:0]  maze;
   logic          busy;
   logic          out_valid;
   logic [RW-1:0] out_row;
   logic [RW-1:0] out_col;
   logic          out_last;
   logic          no_path;

   modport master (
      output in_valid, maze,
      input  busy, out_valid, out_row, out_col, out_last, no_path
   );

   modport slave (
      input  in_valid, maze,
      output busy, out_valid, out_row, out_col, out_last, no_path
   );

endinterface

// File: rtl/maze_path_solver_stack.sv
// Coordinate LIFO holding the current DFS path; zero-latency top and indexed read.
module maze_path_stack
   import maze_pkg::*;
#(
   parameter int PD  = 15,
   parameter int SPW = $clog2(PD + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           push,
   input  logic           pop,
   input  coord_t         push_dat,
   output coord_t         top,
   output logic [SPW-1:0] sp,
   input  logic [SPW-1:0] rd_idx,
   output coord_t         rd_dat
);

   coord_t         mem [PD];
   logic [SPW-1:0] base;

   // A clear in the same cycle as a push restarts the stack with that entry.
   assign base = clear ? '0 : sp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else if (push) begin
         sp <= base + SPW'(1);
      end else if (pop) begin
         sp <= base - SPW'(1);
      end else begin
         sp <= base;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[base] <= push_dat;
      end
   end

   assign top    = (sp == '0) ? '0 : mem[sp - SPW'(1)];
   assign rd_dat = (rd_idx < SPW'(PD)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/maze_path_solver.sv
// Rat-in-a-maze DFS from (0,N-1) to (N-1,0); first beat one cycle after goal found.
// No backpressure: path streams one cell per cycle, in_valid ignored once loaded.
module maze_path_solver
   import maze_pkg::*;
#(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   maze_path_solver_if.slave bus
);

   localparam int RW  = $clog2(N);
   localparam int PD  = 2 * N - 1;
   localparam int SPW = $clog2(PD + 1);
   localparam int SCW = $clog2(2 * N * N + 2);
   localparam coord_t START = start_cell(N);
   localparam coord_t GOAL  = goal_cell(N);

   state_t         state;
   logic [N-1:0]   maze_q [N];
   logic [N-1:0]   dead_q [N];
   logic [RW-1:0]  row_cnt;
   logic [SPW-1:0] out_idx;
   logic [SCW-1:0] search_cnt;

   logic          busy_q;
   logic          out_valid_q;
   logic [RW-1:0] out_row_q;
   logic [RW-1:0] out_col_q;
   logic          out_last_q;
   logic          no_path_q;

   coord_t         top;
   coord_t         rd_dat;
   coord_t         push_dat;
   logic           push;
   logic           pop;
   logic           clear;
   logic [SPW-1:0] sp;

   logic [RW-1:0] r;
   logic [RW-1:0] c;
   logic [RW-1:0] r_dn;
   logic [RW-1:0] c_lf;
   logic          at_goal;
   logic          down_ok;
   logic          left_ok;
   logic          ends_ok;

   maze_path_stack #(.PD(PD)) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (push),
      .pop      (pop),
      .push_dat (push_dat),
      .top      (top),
      .sp       (sp),
      .rd_idx   (out_idx),
      .rd_dat   (rd_dat)
   );

   always_comb begin
      r        = RW'(top.row);
      c        = RW'(top.col);
      r_dn     = r + RW'(1);
      c_lf     = c - RW'(1);
      at_goal  = (top == GOAL);
      // Boundary tests gate the neighbour lookup so wrapped indices never matter.
      down_ok  = (top.row < CW'(N - 1)) && maze_q[r_dn][c] && !dead_q[r_dn][c];
      left_ok  = (top.col != '0) && maze_q[r][c_lf] && !dead_q[r][c_lf];
      ends_ok  = maze_q[0][N-1] && maze_q[N-1][0];
      clear    = (state == CHECK);
      push     = 1'b0;
      pop      = 1'b0;
      push_dat = START;
      if (state == CHECK) begin
         push = ends_ok;
      end else if (state == SEARCH && !at_goal) begin
         if (down_ok) begin
            push     = 1'b1;
            push_dat = '{row: CW'(r_dn), col: top.col};
         end else if (left_ok) begin
            push     = 1'b1;
            push_dat = '{row: top.row, col: CW'(c_lf)};
         end else begin
            pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         row_cnt     <= '0;
         out_idx     <= '0;
         search_cnt  <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         no_path_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            maze_q[i] <= '0;
            dead_q[i] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
         no_path_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  maze_q[0] <= bus.maze;
                  row_cnt   <= RW'(1);
                  busy_q    <= 1'b1;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  maze_q[row_cnt] <= bus.maze;
                  if (row_cnt == RW'(N - 1)) begin
                     state <= CHECK;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end else begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            CHECK: begin
               for (int i = 0; i < N; i++) begin
                  dead_q[i] <= '0;
               end
               out_idx    <= '0;
               search_cnt <= '0;
               if (ends_ok) begin
                  state <= SEARCH;
               end else begin
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b1;
                  no_path_q   <= 1'b1;
                  state       <= FAIL;
               end
            end
            SEARCH: begin
               search_cnt <= search_cnt + SCW'(1);
               if (at_goal) begin
                  out_valid_q <= 1'b1;
                  out_row_q   <= RW'(rd_dat.row);
                  out_col_q   <= RW'(rd_dat.col);
                  out_last_q  <= (out_idx == sp - SPW'(1));
                  out_idx     <= out_idx + SPW'(1);
                  state       <= OUTPUT;
               end else if (!down_ok && !left_ok) begin
                  dead_q[r][c] <= 1'b1;
                  if (sp == SPW'(1)) begin
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b1;
                     no_path_q   <= 1'b1;
                     state       <= FAIL;
                  end
               end
            end
            OUTPUT: begin
               if (out_idx == sp) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  out_valid_q <= 1'b1;
                  out_row_q   <= RW'(rd_dat.row);
                  out_col_q   <= RW'(rd_dat.col);
                  out_last_q  <= (out_idx == sp - SPW'(1));
                  out_idx     <= out_idx + SPW'(1);
               end
            end
            FAIL: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Each cell is pushed and popped at most once, so DFS must finish within 2*N*N cycles.
   always @(posedge clk) begin
      if (rst_n && state == SEARCH) begin
         assert (int'(search_cnt) < 2 * N * N);
      end
   end

   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_row   = out_row_q;
   assign bus.out_col   = out_col_q;
   assign bus.out_last  = out_last_q;
   assign bus.no_path   = no_path_q;

endmodule
